// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: op_sel codes, MIPS opcodes and loader FSM states shared by the encoder/loader
package instr_enc_pkg;
    typedef enum logic [2:0] {
        OP_RTYPE   = 3'd0,
        OP_ADDI    = 3'd1,
        OP_ANDI    = 3'd2,
        OP_SLTI    = 3'd3,
        OP_LW      = 3'd4,
        OP_SW      = 3'd5,
        OP_BEQ     = 3'd6,
        OP_ILLEGAL = 3'd7
    } opSelE;
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } stateE;
endpackage

// File: rtl/instr_field_packer.sv
// instr_field_packer: combinational packing of symbolic fields into a 32-bit MIPS word
module instr_field_packer
    import instr_enc_pkg::*;
(
    input  logic [2:0]  opSel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    logic [5:0] opcode;
    // select the I-type opcode; op_sel 7 has no encoding and is flagged illegal
    always_comb begin
        opcode = OPC_RTYPE;
        legal  = 1'b1;
        case (opSelE'(opSel))
            OP_ADDI: opcode = OPC_ADDI;
            OP_ANDI: opcode = OPC_ANDI;
            OP_SLTI: opcode = OPC_SLTI;
            OP_LW:   opcode = OPC_LW;
            OP_SW:   opcode = OPC_SW;
            OP_BEQ:  opcode = OPC_BEQ;
            OP_RTYPE: opcode = OPC_RTYPE;
            default: legal = 1'b0;
        endcase
    end
    assign word = (opSel == OP_RTYPE) ? {OPC_RTYPE, rs, rt, rd, 5'b00000, funct}
                                      : {opcode, rs, rt, imm};
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts instruction fields and writes packed words to consecutive imem slots
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        op_sel_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    output logic              we_o,
    output logic [31:0]       waddr_o,
    output logic [31:0]       wdata_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              done_o,
    output logic              err_o
);
    stateE state, stateNext;
    logic [ADDR_W:0]   acceptCnt, acceptNext;
    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       packedWord;
    logic              legal, accept, writeNow;

    instr_field_packer packer (
        .opSel (op_sel_i),
        .rs    (rs_i),
        .rt    (rt_i),
        .rd    (rd_i),
        .funct (funct_i),
        .imm   (imm_i),
        .word  (packedWord),
        .legal (legal)
    );

    // the MSB of the accept count marks a full session (count == DEPTH)
    assign in_ready_o = (state == ST_LOAD) && !acceptCnt[ADDR_W];
    assign done_o     = (state == ST_DONE);
    assign accept     = in_valid_i && in_ready_o;
    assign writeNow   = accept && legal;
    assign acceptNext = acceptCnt + (ADDR_W+1)'(accept);

    // next state: start always (re)opens a session; finish or the final accept closes it
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: stateNext = start_i ? ST_LOAD : ST_IDLE;
            ST_LOAD: stateNext = start_i ? ST_LOAD
                               : (finish_i || acceptNext[ADDR_W]) ? ST_DONE : ST_LOAD;
            ST_DONE: stateNext = start_i ? ST_LOAD : ST_DONE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // state, session counters, sticky error and the one-cycle write stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            acceptCnt    <= '0;
            wordIdx      <= '0;
            word_count_o <= '0;
            err_o        <= 1'b0;
            we_o         <= 1'b0;
            waddr_o      <= BASE_ADDR;
            wdata_o      <= '0;
        end else begin
            state <= stateNext;
            we_o  <= writeNow;
            if (writeNow) begin
                waddr_o <= BASE_ADDR + 32'({wordIdx, 2'b00});
                wdata_o <= packedWord;
            end
            if (start_i) begin
                acceptCnt    <= '0;
                wordIdx      <= '0;
                word_count_o <= '0;
                err_o        <= 1'b0;
            end else begin
                acceptCnt    <= acceptNext;
                wordIdx      <= wordIdx + ADDR_W'(writeNow);
                word_count_o <= word_count_o + (ADDR_W+1)'(we_o);
                if (accept && !legal)
                    err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed vectors, corner sequences and a randomized run against a reference model
module tb_instr_encoder_loader;
    localparam int          ADDR_W = 2;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] BASE   = 32'h0000_0000;

    logic clk_i = 1'b0;
    logic rst_i, start_i, finish_i, in_valid_i, in_ready_o;
    logic [2:0]  op_sel_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic we_o, done_o, err_o;
    logic [31:0] waddr_o, wdata_o;
    logic [ADDR_W:0] word_count_o;

    int checks = 0;
    int errors = 0;

    int mState;
    int mAccepted;
    int mIdx;
    int eCount;
    logic eWe, eErr;
    logic [31:0] eAddr, eData;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] word;
        logic        legal;
    } vecT;
    vecT vecs[9];

    instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .finish_i     (finish_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .op_sel_i     (op_sel_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .funct_i      (funct_i),
        .imm_i        (imm_i),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .word_count_o (word_count_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] encode(input int op, input int rs, input int rt,
                                           input int rd, input int funct, input int imm);
        int opc[7];
        opc = '{0, 8, 12, 10, 35, 43, 4};
        if (op == 0)
            return 32'(rs * 2**21 + rt * 2**16 + rd * 2**11 + funct);
        return 32'(longint'(opc[op]) * 2**26 + rs * 2**21 + rt * 2**16 + imm);
    endfunction

    // abstract session model: 0 idle, 1 loading, 2 done; evaluated on the inputs about to be sampled
    task automatic modelStep();
        bit ready, acc, lg;
        if (rst_i) begin
            mState = 0; mAccepted = 0; mIdx = 0; eCount = 0;
            eWe = 0; eErr = 0; eAddr = BASE; eData = 0;
            return;
        end
        ready = (mState == 1) && (mAccepted < DEPTH);
        acc = ready && in_valid_i;
        lg = (op_sel_i != 3'd7);
        eCount = start_i ? 0 : eCount + int'(eWe);
        eWe = acc && lg;
        if (eWe) begin
            eAddr = BASE + 32'(4 * mIdx);
            eData = encode(int'(op_sel_i), int'(rs_i), int'(rt_i), int'(rd_i), int'(funct_i), int'(imm_i));
            mIdx = (mIdx + 1) % DEPTH;
        end
        if (acc) mAccepted++;
        if (acc && !lg) eErr = 1;
        if (start_i) begin
            mAccepted = 0; mIdx = 0; eErr = 0; mState = 1;
        end else if (mState == 1 && (finish_i || mAccepted == DEPTH))
            mState = 2;
    endtask

    task automatic modelCompare();
        chk("m_we", 32'(we_o), 32'(eWe));
        chk("m_waddr", waddr_o, eAddr);
        chk("m_wdata", wdata_o, eData);
        chk("m_count", 32'(word_count_o), 32'(eCount % (2 * DEPTH)));
        chk("m_err", 32'(err_o), 32'(eErr));
        chk("m_done", 32'(done_o), 32'(mState == 2));
        chk("m_ready", 32'(in_ready_o), 32'((mState == 1) && (mAccepted < DEPTH)));
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk_i);
        #1;
        modelCompare();
    endtask

    task automatic setOp(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm);
        op_sel_i = op; rs_i = rs; rt_i = rt; rd_i = rd; funct_i = funct; imm_i = imm;
    endtask

    task automatic startSession();
        start_i = 1; tick(); start_i = 0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  6'h20, 16'hABCD, 32'h00221820, 1'b1};
        vecs[1] = '{3'd1, 5'd0,  5'd1,  5'd9,  6'h3F, 16'h0005, 32'h20010005, 1'b1};
        vecs[2] = '{3'd2, 5'd3,  5'd5,  5'd0,  6'h00, 16'h00FF, 32'h306500FF, 1'b1};
        vecs[3] = '{3'd3, 5'd31, 5'd31, 5'd7,  6'h11, 16'h8000, 32'h2BFF8000, 1'b1};
        vecs[4] = '{3'd4, 5'd1,  5'd4,  5'd0,  6'h00, 16'h0008, 32'h8C240008, 1'b1};
        vecs[5] = '{3'd5, 5'd0,  5'd4,  5'd0,  6'h00, 16'h0004, 32'hAC040004, 1'b1};
        vecs[6] = '{3'd6, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 32'h1022FFFF, 1'b1};
        vecs[7] = '{3'd0, 5'd31, 5'd0,  5'd31, 6'h2A, 16'h1234, 32'h03E0F82A, 1'b1};
        vecs[8] = '{3'd7, 5'd1,  5'd1,  5'd1,  6'h01, 16'h0001, 32'h00000000, 1'b0};

        rst_i = 1; start_i = 0; finish_i = 0; in_valid_i = 0;
        setOp(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
        tick(); tick();
        rst_i = 0;
        chk("rst_ready", 32'(in_ready_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_waddr", waddr_o, BASE);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_count", 32'(word_count_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        for (int i = 0; i < 9; i++) begin
            startSession();
            chk("vec_ready", 32'(in_ready_o), 32'd1);
            setOp(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct, vecs[i].imm);
            in_valid_i = 1; tick(); in_valid_i = 0;
            chk("vec_we", 32'(we_o), 32'(vecs[i].legal));
            chk("vec_err", 32'(err_o), 32'(!vecs[i].legal));
            if (vecs[i].legal) begin
                chk("vec_wdata", wdata_o, vecs[i].word);
                chk("vec_waddr", waddr_o, BASE);
            end
            tick();
            chk("vec_we_off", 32'(we_o), 32'd0);
            chk("vec_count", 32'(word_count_o), 32'(vecs[i].legal));
        end

        startSession();
        setOp(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'd0);
        in_valid_i = 1; tick();
        chk("b2b_d0", wdata_o, 32'h00221820);
        chk("b2b_a0", waddr_o, 32'h0);
        setOp(3'd4, 5'd1, 5'd4, 5'd0, 6'd0, 16'h0008);
        tick(); in_valid_i = 0;
        chk("b2b_we1", 32'(we_o), 32'd1);
        chk("b2b_d1", wdata_o, 32'h8C240008);
        chk("b2b_a1", waddr_o, 32'h4);
        tick();
        chk("b2b_count", 32'(word_count_o), 32'd2);

        startSession();
        setOp(3'd6, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF);
        in_valid_i = 1; tick();
        chk("fin_d0", wdata_o, 32'h1022FFFF);
        setOp(3'd5, 5'd0, 5'd4, 5'd0, 6'd0, 16'h0004);
        finish_i = 1; tick(); finish_i = 0; in_valid_i = 0;
        chk("fin_d1", wdata_o, 32'hAC040004);
        chk("fin_a1", waddr_o, 32'h4);
        chk("fin_done", 32'(done_o), 32'd1);
        chk("fin_ready", 32'(in_ready_o), 32'd0);

        startSession();
        in_valid_i = 1;
        for (int i = 0; i < DEPTH; i++) begin
            setOp(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'(i));
            tick();
            chk("full_we", 32'(we_o), 32'd1);
            chk("full_addr", waddr_o, 32'(4 * i));
            chk("full_data", wdata_o, 32'h20010000 + 32'(i));
        end
        chk("full_ready", 32'(in_ready_o), 32'd0);
        chk("full_done", 32'(done_o), 32'd1);
        tick(); in_valid_i = 0;
        chk("full_we_off", 32'(we_o), 32'd0);
        chk("full_count", 32'(word_count_o), 32'(DEPTH));

        startSession();
        setOp(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'd1);
        in_valid_i = 1; tick();
        chk("ill_a0", waddr_o, 32'h0);
        setOp(3'd7, 5'd0, 5'd1, 5'd0, 6'd0, 16'd9);
        tick();
        chk("ill_we", 32'(we_o), 32'd0);
        chk("ill_err", 32'(err_o), 32'd1);
        setOp(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'd2);
        tick(); in_valid_i = 0;
        chk("ill_a1", waddr_o, 32'h4);
        chk("ill_d1", wdata_o, 32'h20010002);
        tick();
        chk("ill_count", 32'(word_count_o), 32'd2);
        startSession();
        chk("ill_clear", 32'(err_o), 32'd0);

        setOp(3'd1, 5'd0, 5'd1, 5'd0, 6'd0, 16'd3);
        in_valid_i = 1; rst_i = 1; tick(); rst_i = 0; in_valid_i = 0;
        chk("rstacc_we", 32'(we_o), 32'd0);
        chk("rstacc_ready", 32'(in_ready_o), 32'd0);
        startSession();
        in_valid_i = 1; tick(); in_valid_i = 0;
        chk("rstfly_we_pre", 32'(we_o), 32'd1);
        rst_i = 1; tick(); rst_i = 0;
        chk("rstfly_we", 32'(we_o), 32'd0);
        chk("rstfly_count", 32'(word_count_o), 32'd0);
        chk("rstfly_done", 32'(done_o), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 255) == 0);
            in_valid_i = ($urandom_range(0, 9) < 7);
            setOp(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
            finish_i = ($urandom_range(0, 19) == 0);
            if (mState == 1) begin
                start_i = ($urandom_range(0, 39) == 0);
                if (start_i) in_valid_i = 0;
            end else
                start_i = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
